// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one asynchronous-read Memory port between two masters:
//   master 0 = CPU, master 1 = program loader / DMA engine.
// A registered ownership FSM (IDLE / OWN0 / OWN1) decides who drives the
// bus. Every mem_* output is a pure mux of the current owner's signals,
// so a non-owner's address or data never reaches the Memory. IDLE drives
// all zeros, so no write can occur in IDLE.
// A hold counter limits how long one master can keep the bus while the
// other master is waiting.
//
// Parameters:
//   AW        address width
//   DW        data width
//   MAX_HOLD  maximum consecutive owned cycles while the other master is
//             requesting (0 = never preempt)
//
// Optional build macro:
//   ARB_RR_EN  when defined, a simultaneous request in IDLE goes to the
//              master that did not own the bus last (last_owner register).
//              When undefined, master 0 always wins such a tie.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   mX_req/addr/wr/mode/wdata master X request and bus fields (X = 0, 1)
//   mX_gnt                    master X owns the bus
//   mX_valid                  read data on rdata is valid for master X
//   rdata                     Memory read data, shared by both masters
//   mem_addr/wr/mode/wdata    to the Memory
//   mem_rdata                 from the Memory (asynchronous read)
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_wr,
    input  logic          m0_mode,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_valid,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_wr,
    input  logic          m1_mode,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_valid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic          mem_mode,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    // clog2(MAX_HOLD+1) collapses to 0 when MAX_HOLD is 0; keep one bit.
    localparam int          HW         = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit          PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HW-1:0] HOLD_LAST = PREEMPT_EN ? HW'(MAX_HOLD - 1) : '0;

    logic [1:0]    state_reg, state_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;

    logic [1:0] req_vec;
    logic [1:0] wr_vec;
    logic [1:0] gnt_vec;
    logic [1:0] valid_vec;

    assign req_vec = {m1_req, m0_req};
    assign wr_vec  = {m1_wr,  m0_wr};

    // Grant and read-valid are decoded straight from the registered state;
    // valid is same-cycle because the Memory read is asynchronous.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            localparam logic [1:0] OWN_ST = (gi == 0) ? OWN0 : OWN1;
            assign gnt_vec[gi]   = (state_reg == OWN_ST);
            assign valid_vec[gi] = gnt_vec[gi] & req_vec[gi] & ~wr_vec[gi];
        end
    endgenerate

    assign m0_gnt   = gnt_vec[0];
    assign m1_gnt   = gnt_vec[1];
    assign m0_valid = valid_vec[0];
    assign m1_valid = valid_vec[1];
    assign rdata    = mem_rdata;

    // Winner of a simultaneous request seen in IDLE.
    logic [1:0] tie_state;
`ifdef ARB_RR_EN
    logic last_owner_reg;
    assign tie_state = last_owner_reg ? OWN0 : OWN1;
`else
    assign tie_state = OWN0;
`endif

    logic       own_req;
    logic       oth_req;
    logic [1:0] oth_state;

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        own_req       = 1'b0;
        oth_req       = 1'b0;
        oth_state     = IDLE;
        case (state_reg)
            IDLE: begin
                hold_cnt_next = '0;
                if (m0_req && m1_req) begin
                    state_next = tie_state;
                end else if (m0_req) begin
                    state_next = OWN0;
                end else if (m1_req) begin
                    state_next = OWN1;
                end
            end
            OWN0, OWN1: begin
                own_req   = (state_reg == OWN0) ? m0_req : m1_req;
                oth_req   = (state_reg == OWN0) ? m1_req : m0_req;
                oth_state = (state_reg == OWN0) ? OWN1 : OWN0;
                if (!own_req) begin
                    // Release: hand over directly when the other master waits,
                    // so there is no IDLE bubble between owners.
                    state_next = oth_req ? oth_state : IDLE;
                end else if (oth_req) begin
                    if (PREEMPT_EN && (hold_cnt_reg == HOLD_LAST)) begin
                        state_next = oth_state;
                    end else if (PREEMPT_EN) begin
                        hold_cnt_next = hold_cnt_reg + HW'(1);
                    end
                end else begin
                    hold_cnt_next = '0;
                end
                if (state_next != state_reg) begin
                    hold_cnt_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

`ifdef ARB_RR_EN
    // Reset value 1 makes master 0 the first tie winner after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_reg <= 1'b1;
        end else if ((state_next == OWN0) && (state_reg != OWN0)) begin
            last_owner_reg <= 1'b0;
        end else if ((state_next == OWN1) && (state_reg != OWN1)) begin
            last_owner_reg <= 1'b1;
        end
    end
`endif

    // Bus mux: only the owner reaches the Memory. The write strobe is also
    // gated by the owner's req so a master that has just released cannot
    // write during its last owned cycle.
    always_comb begin
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_mode  = 1'b0;
        mem_wdata = '0;
        case (state_reg)
            OWN0: begin
                mem_addr  = m0_addr;
                mem_wr    = m0_wr & m0_req;
                mem_mode  = m0_mode;
                mem_wdata = m0_wdata;
            end
            OWN1: begin
                mem_addr  = m1_addr;
                mem_wr    = m1_wr & m1_req;
                mem_mode  = m1_mode;
                mem_wdata = m1_wdata;
            end
            default: begin
                mem_addr  = '0;
                mem_wr    = 1'b0;
                mem_mode  = 1'b0;
                mem_wdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter with a behavioural asynchronous-read
// Memory. Expected read data is pushed to a per-master queue when a read is
// issued (taken from a shadow copy of the memory that the bench updates for
// every write it issues) and popped when the DUT raises mX_valid.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_wr = 1'b0, m0_mode = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_wr = 1'b0, m1_mode = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_gnt, m0_valid, m1_gnt, m1_valid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wr, mem_mode;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem    [1024];
    logic [DW-1:0] shadow [1024];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_mode(m0_mode),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_valid(m0_valid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_mode(m1_mode),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_valid(m1_valid),
        .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_mode(mem_mode),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: asynchronous read, synchronous write.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard / protocol monitor.
    always @(negedge clk) begin
        if (m0_valid) begin
            if (q0.size() == 0) check("m0_unexpected_valid", 32'd1, 32'd0);
            else begin
                $display("txn m0 read addr=%h rdata=%h exp=%h", mem_addr, rdata, q0[0]);
                check("m0_rdata", 32'(rdata), 32'(q0.pop_front()));
            end
        end
        if (m1_valid) begin
            if (q1.size() == 0) check("m1_unexpected_valid", 32'd1, 32'd0);
            else begin
                $display("txn m1 read addr=%h rdata=%h exp=%h", mem_addr, rdata, q1[0]);
                check("m1_rdata", 32'(rdata), 32'(q1.pop_front()));
            end
        end
        check("gnt_exclusive", 32'(m0_gnt & m1_gnt), 32'd0);
        check("wr_without_owner", 32'(mem_wr & ~(m0_gnt | m1_gnt)), 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_wr = 1'b0; m0_mode = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_mode = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Single read from an idle arbiter; data is checked by the monitor.
    task automatic do_read(input int m, input logic [AW-1:0] a);
        if (m == 0) begin
            m0_req = 1'b1; m0_wr = 1'b0; m0_addr = a; q0.push_back(shadow[a]);
        end else begin
            m1_req = 1'b1; m1_wr = 1'b0; m1_addr = a; q1.push_back(shadow[a]);
        end
        step();
        @(negedge clk);
        check((m == 0) ? "rd_gnt0" : "rd_gnt1", 32'((m == 0) ? m0_gnt : m1_gnt), 32'd1);
        step();
        idle_inputs();
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_w;
        for (int i = 0; i < 1024; i++) begin
            mem[i]    = 16'(i * 37 + 'h100);
            shadow[i] = 16'(i * 37 + 'h100);
        end

        // ---- reset state ----
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        @(negedge clk);
        check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        check("rst_valid", 32'({m0_valid, m1_valid}), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_mode", 32'(mem_mode), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        step();
        rst = 1'b0;
        step();

        // ---- m0 read of word 5, 1-cycle grant ----
        m0_req = 1'b1; m0_wr = 1'b0; m0_mode = 1'b1; m0_addr = 10'h005;
        q0.push_back(shadow[5]);
        @(negedge clk);
        check("t1_gnt_before_edge", 32'(m0_gnt), 32'd0);
        step();
        @(negedge clk);
        check("t1_m0_gnt", 32'(m0_gnt), 32'd1);
        check("t1_m1_gnt", 32'(m1_gnt), 32'd0);
        check("t1_mem_addr", 32'(mem_addr), 32'h005);
        check("t1_mem_mode", 32'(mem_mode), 32'd1);
        check("t1_m0_valid", 32'(m0_valid), 32'd1);
        step();
        idle_inputs();
        step();
        step();
        @(negedge clk);
        check("t1_back_idle", 32'({m0_gnt, m1_gnt}), 32'd0);

        // ---- m1 write 0xBEEF to 0x3FF, then read back ----
        step();
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 10'h3FF; m1_wdata = 16'hBEEF;
        @(negedge clk);
        check("t2_wr_before_gnt", 32'(mem_wr), 32'd0);
        check("t2_gnt_before_edge", 32'(m1_gnt), 32'd0);
        step();
        @(negedge clk);
        check("t2_m1_gnt", 32'(m1_gnt), 32'd1);
        check("t2_mem_wr", 32'(mem_wr), 32'd1);
        check("t2_mem_addr", 32'(mem_addr), 32'h3FF);
        check("t2_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        shadow[10'h3FF] = 16'hBEEF;
        $display("txn m1 write addr=3ff data=beef");
        step();
        m1_req = 1'b0;
        @(negedge clk);
        check("t2_wr_after_release", 32'(mem_wr), 32'd0);
        step();
        idle_inputs();
        step();
        do_read(0, 10'h3FF);

        // ---- simultaneous requests, four idle-separated rounds ----
        do_reset();
        for (int r = 0; r < 4; r++) begin
`ifdef ARB_RR_EN
            exp_w = 2'(r % 2);
`else
            exp_w = 2'd0;
`endif
            m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 10'(10 + r);
            m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 10'(20 + r);
            if (exp_w == 2'd0) q0.push_back(shadow[10 + r]);
            else               q1.push_back(shadow[20 + r]);
            step();
            @(negedge clk);
            check("tie_m0_gnt", 32'(m0_gnt), 32'(exp_w == 2'd0));
            check("tie_m1_gnt", 32'(m1_gnt), 32'(exp_w == 2'd1));
            step();
            idle_inputs();
            step();
            step();
        end

        // ---- preemption: m0 writes continuously while m1 waits to read ----
        m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 10'd30; m0_wdata = 16'h1234;
        shadow[30] = 16'h1234;
        step();
        m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 10'd30;
        q1.push_back(16'h1234);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("pre_m0_hold", 32'({m0_gnt, m1_gnt}), 32'b10);
            step();
        end
        @(negedge clk);
        check("pre_m0_dropped", 32'(m0_gnt), 32'd0);
        check("pre_m1_granted", 32'(m1_gnt), 32'd1);
        check("pre_nonowner_wr", 32'(mem_wr), 32'd0);
        step();
        m1_req = 1'b0;
        @(negedge clk);
        check("pre_m1_release_wr", 32'(mem_wr), 32'd0);
        step();
        @(negedge clk);
        check("pre_m0_regrant", 32'({m0_gnt, m1_gnt}), 32'b10);
        step();
        step();
        idle_inputs();
        step();
        step();
        do_read(1, 10'd30);

        // ---- handover on release, new owner writes ----
        m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 10'd60;
        q0.push_back(shadow[60]);
        step();
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 10'd61; m1_wdata = 16'h5555;
        @(negedge clk);
        check("ho_nonowner_addr", 32'(mem_addr), 32'd60);
        check("ho_nonowner_wr", 32'(mem_wr), 32'd0);
        step();
        m0_req = 1'b0;
        @(negedge clk);
        check("ho_release_wr", 32'(mem_wr), 32'd0);
        step();
        @(negedge clk);
        check("ho_direct_switch", 32'({m0_gnt, m1_gnt}), 32'b01);
        check("ho_new_owner_wr", 32'(mem_wr), 32'd1);
        check("ho_new_owner_addr", 32'(mem_addr), 32'd61);
        shadow[61] = 16'h5555;
        $display("txn m1 write addr=03d data=5555");
        step();
        idle_inputs();
        step();
        step();
        do_read(0, 10'd61);

        // ---- reset while m1 is writing ----
        m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 10'd70; m1_wdata = 16'hDEAD;
        step();
        @(negedge clk);
        check("rw_pre_wr", 32'(mem_wr), 32'd1);
        rst = 1'b1;
        step();
        // This granted cycle's write lands on the reset edge itself.
        shadow[70] = 16'hDEAD;
        m1_wdata = 16'hBAD0;
        @(negedge clk);
        check("rw_gnt", 32'({m0_gnt, m1_gnt}), 32'd0);
        check("rw_mem_wr", 32'(mem_wr), 32'd0);
        check("rw_mem_addr", 32'(mem_addr), 32'd0);
        step();
        @(negedge clk);
        check("rw_mem_wr_hold", 32'(mem_wr), 32'd0);
        rst = 1'b0;
        idle_inputs();
        step();
        @(negedge clk);
        check("rw_idle_after", 32'({m0_gnt, m1_gnt}), 32'd0);
        step();
        do_read(0, 10'd70);

        step();
        step();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
